// File: rtl/time_entry_loader_pkg.sv
// time_entry_loader_pkg
//   Shared constants and types for the keypad time-entry loader:
//   key codes, FSM state encoding, BCD digit width, the M:SS time struct,
//   the quick-start (0:30) value and the 9:59 saturation value.
package time_entry_loader_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_START = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] mins;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_time_t;

  localparam bcd_time_t QS_TIME  = '{mins: 4'd0, tens: 4'd3, ones: 4'd0};
  localparam bcd_time_t MAX_TIME = '{mins: 4'd9, tens: 4'd5, ones: 4'd9};

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/time_entry_loader_bcd_add30.sv
// time_entry_loader_bcd_add30
//   Combinational +30 s adder on a 3-digit BCD M:SS value. The seconds-tens
//   digit wraps at 6 with carry into minutes; anything past 9:59 saturates.
//   Input seconds-tens is assumed already validated (<= 5).
// Ports:
//   t_i  in   bcd_time_t  current M:SS value
//   t_o  out  bcd_time_t  value + 0:30, saturated at 9:59
module time_entry_loader_bcd_add30
  import time_entry_loader_pkg::*;
(
  input  bcd_time_t t_i,
  output bcd_time_t t_o
);

  logic [DIGIT_W:0] tens_sum;

  always_comb begin
    t_o      = t_i;
    tens_sum = {1'b0, t_i.tens} + 5'd3;
    if (tens_sum >= 5'd6) begin
      if (t_i.mins >= 4'd9) begin
        t_o = MAX_TIME;
      end else begin
        t_o.mins = t_i.mins + 4'd1;
        t_o.tens = tens_sum[DIGIT_W-1:0] - 4'd6;
      end
    end else begin
      t_o.tens = tens_sum[DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/time_entry_loader.sv
// time_entry_loader
//   Keypad-side writer for the microwave down-counter chain. Shifts BCD digit
//   keys into an M:SS value, validates it on START, pulses the active-low
//   parallel load of the counters, enables counting and returns to idle on
//   the chain's zero flag. Door opening in RUN pauses; START resumes.
//   Optional feature macro: QUICK_START_EN (START in IDLE loads 0:30, START
//   while running adds 30 s with 9:59 saturation and reloads).
// Parameters:
//   MAX_SEC_TENS  largest legal seconds-tens digit
//   LOAD_CYCLES   cycles loadn is held low (1..3)
// Ports:
//   clock, clrn              clock (rising) / async active-low reset
//   key_valid, key_code      one-cycle key strobe and code
//   door_closed, timer_zero  door switch / counter chain zero flag
//   mins, sec_tens, sec_ones BCD data buses to the counters
//   loadn, count_en          counter load (active low) / count enable
//   err, busy                rejected-START pulse / LOAD-or-RUN indicator
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int MAX_SEC_TENS = 5,
  parameter int LOAD_CYCLES  = 1
) (
  input  logic               clock,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] mins,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               loadn,
  output logic               count_en,
  output logic               err,
  output logic               busy
);

  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX_SEC_TENS);
  localparam logic [1:0]         LAST_LD  = 2'(LOAD_CYCLES - 1);

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d, time_add30;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] ld_cnt_q, ld_cnt_d;
  logic      loadn_q, loadn_d;
  logic      count_en_q, count_en_d;
  logic      err_q, err_d;
  logic      busy_q, busy_d;
  // Low during the first RUN cycle: the zero flag then still reflects the
  // counters' pre-load contents.
  logic      armed_q, armed_d;

  logic key_digit, key_clr, key_start, time_ok;

  time_entry_loader_bcd_add30 u_add30 (
    .t_i (time_q),
    .t_o (time_add30)
  );

`ifndef QUICK_START_EN
  logic unused_add30;
  assign unused_add30 = ^time_add30;
`endif

  assign key_digit = key_valid && is_digit(key_code);
  assign key_clr   = key_valid && (key_code == KEY_CLEAR);
  assign key_start = key_valid && (key_code == KEY_START);
  assign time_ok   = (time_q.tens <= MAX_TENS) && (time_q != '0);

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    cnt_d      = cnt_q;
    ld_cnt_d   = ld_cnt_q;
    loadn_d    = loadn_q;
    count_en_d = count_en_q;
    err_d      = 1'b0;
    armed_d    = armed_q;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_digit) begin
          time_d  = '{mins: time_q.tens, tens: time_q.ones, ones: key_code};
          cnt_d   = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
          state_d = ST_ENTRY;
        end else if (key_clr) begin
          time_d  = '0;
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (key_start && door_closed) begin
          if (state_q == ST_ENTRY) begin
            if (time_ok) begin
              state_d  = ST_LOAD;
              loadn_d  = 1'b0;
              ld_cnt_d = 2'd0;
            end else begin
              err_d = 1'b1;
            end
          end
`ifdef QUICK_START_EN
          else begin
            time_d   = QS_TIME;
            state_d  = ST_LOAD;
            loadn_d  = 1'b0;
            ld_cnt_d = 2'd0;
          end
`endif
        end
      end

      ST_LOAD: begin
        if (ld_cnt_q == LAST_LD) begin
          state_d    = ST_RUN;
          loadn_d    = 1'b1;
          count_en_d = 1'b1;
          armed_d    = 1'b0;
        end else begin
          ld_cnt_d = ld_cnt_q + 2'd1;
        end
      end

      ST_RUN: begin
        armed_d = 1'b1;
        // Zero flag outranks any key arriving in the same cycle.
        if ((timer_zero && count_en_q && armed_q) || key_clr) begin
          state_d    = ST_IDLE;
          time_d     = '0;
          cnt_d      = 2'd0;
          count_en_d = 1'b0;
        end else if (!door_closed) begin
          count_en_d = 1'b0;
        end else if (key_start) begin
          if (!count_en_q) begin
            count_en_d = 1'b1;
          end
`ifdef QUICK_START_EN
          else begin
            time_d     = time_add30;
            state_d    = ST_LOAD;
            loadn_d    = 1'b0;
            ld_cnt_d   = 2'd0;
            count_en_d = 1'b0;
          end
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      cnt_q      <= 2'd0;
      ld_cnt_q   <= 2'd0;
      loadn_q    <= 1'b1;
      count_en_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      cnt_q      <= cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      loadn_q    <= loadn_d;
      count_en_q <= count_en_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
    end
  end

  assign mins     = time_q.mins;
  assign sec_tens = time_q.tens;
  assign sec_ones = time_q.ones;
  assign loadn    = loadn_q;
  assign count_en = count_en_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_time_entry_loader.sv
module tb_time_entry_loader;

  localparam int LC  = 2;
  localparam int MST = 5;

  logic       clock, clrn, key_valid, door_closed, timer_zero;
  logic [3:0] key_code, mins, sec_tens, sec_ones;
  logic       loadn, count_en, err, busy;

  time_entry_loader #(.MAX_SEC_TENS(MST), .LOAD_CYCLES(LC)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .door_closed(door_closed), .timer_zero(timer_zero), .mins(mins),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .loadn(loadn),
    .count_en(count_en), .err(err), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: mode 0=idle 1=entry 2=load 3=run; time kept as the
  // decimal number M*100 + ST*10 + SO.
  int m_md, m_val, m_ldrem, m_age;
  bit m_loadn, m_cen, m_err;

  task automatic model_reset();
    m_md = 0; m_val = 0; m_ldrem = 0; m_age = 0;
    m_loadn = 1; m_cen = 0; m_err = 0;
  endtask

  function automatic int add30(input int v);
    int secs;
    secs = (v / 100) * 60 + (v % 100) + 30;
    if (secs > 599) secs = 599;
    return (secs / 60) * 100 + (secs % 60);
  endfunction

  task automatic enter_load();
    m_md = 2; m_loadn = 0; m_ldrem = LC;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit dc, input bit tz);
    bit dig, clr, st, zero;
    dig = kv && (kc <= 9);
    clr = kv && (kc == 10);
    st  = kv && (kc == 11);
    m_err = 0;
    case (m_md)
      0, 1: begin
        if (dig) begin
          m_val = (m_val % 100) * 10 + kc;
          m_md = 1;
        end else if (clr) begin
          m_val = 0; m_md = 0;
        end else if (st && dc) begin
          if (m_md == 1) begin
            if ((m_val / 10) % 10 > MST || m_val == 0) m_err = 1;
            else enter_load();
          end else begin
`ifdef QUICK_START_EN
            m_val = 30;
            enter_load();
`endif
          end
        end
      end
      2: begin
        m_ldrem--;
        if (m_ldrem == 0) begin
          m_md = 3; m_loadn = 1; m_cen = 1; m_age = 0;
        end
      end
      default: begin
        zero = tz && m_cen && (m_age >= 1);
        if (m_age < 2) m_age++;
        if (zero || clr) begin
          m_md = 0; m_val = 0; m_cen = 0;
        end else if (!dc) begin
          m_cen = 0;
        end else if (st) begin
          if (!m_cen) m_cen = 1;
`ifdef QUICK_START_EN
          else begin
            m_val = add30(m_val);
            enter_load();
            m_cen = 0;
          end
`endif
        end
      end
    endcase
  endtask

  task automatic compare(input string name);
    logic [15:0] act, exp;
    act = {mins, sec_tens, sec_ones, loadn, count_en, err, busy};
    exp = {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10),
           m_loadn, m_cen, m_err, (m_md >= 2) ? 1'b1 : 1'b0};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got {m,st,so,ldn,cen,err,busy}=%h expected %h",
                  name, $time, act, exp);
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: drive inputs, let the edge happen, step model, compare.
  task automatic cycle(input bit kv, input int kc, input bit dc, input bit tz);
    key_valid = kv; key_code = 4'(kc); door_closed = dc; timer_zero = tz;
    @(posedge clock);
    model_step(kv, kc, dc, tz);
    #1;
    compare("cycle");
  endtask

  task automatic key(input int kc, input bit dc);
    cycle(1, kc, dc, 0);
  endtask

  // After an accepted START: counts loadn-low cycles until count_en rises.
  task automatic wait_run(output int lows);
    bit done;
    done = 0;
    lows = loadn ? 0 : 1;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle(0, 0, 1, 0);
      if (count_en) done = 1;
      else if (!loadn) lows++;
    end
    if (!done) check_lit("run_timeout", 0, 1);
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #2;
    model_reset();
    @(posedge clock);
    #2 clrn = 1'b1;
  endtask

  initial begin
    int lows;
    key_valid = 0; key_code = 0; door_closed = 1; timer_zero = 0;
    do_reset();
    check_lit("rst_loadn", loadn, 1);
    check_lit("rst_busy", busy, 0);
    check_lit("rst_digits", {mins, sec_tens, sec_ones}, 0);
    compare("reset");

    // 1,2,5 START -> 1:25 loaded for LC cycles, then counting.
    key(1, 1); key(2, 1); key(5, 1);
    key(11, 1);
    check_lit("load_busy", busy, 1);
    wait_run(lows);
    check_lit("load_low_cycles", lows, LC);
    check_lit("run_cen", count_en, 1);
    check_lit("run_digits", {mins, sec_tens, sec_ones}, 12'h125);

    // Zero flag with a simultaneous digit: zero wins.
    cycle(0, 0, 1, 0);
    cycle(1, 7, 1, 1);
    check_lit("zero_cen", count_en, 0);
    check_lit("zero_digits", {mins, sec_tens, sec_ones}, 0);
    check_lit("zero_busy", busy, 0);

    // 9,7,0 START rejected, then CLEAR.
    key(9, 1); key(7, 1); key(0, 1);
    key(11, 1);
    check_lit("bad_err", err, 1);
    check_lit("bad_loadn", loadn, 1);
    check_lit("bad_digits", {mins, sec_tens, sec_ones}, 12'h970);
    cycle(0, 0, 1, 0);
    check_lit("bad_err_pulse", err, 0);
    key(10, 1);
    check_lit("clr_digits", {mins, sec_tens, sec_ones}, 0);

    // 0:00 is rejected too.
    key(0, 1); key(11, 1);
    check_lit("zero_time_err", err, 1);
    key(10, 1);

    // Four digits drop the leading one; START with door open ignored.
    key(1, 1); key(2, 1); key(3, 1); key(4, 1);
    check_lit("shift4_digits", {mins, sec_tens, sec_ones}, 12'h234);
    key(11, 0);
    check_lit("door_open_err", err, 0);
    check_lit("door_open_loadn", loadn, 1);

    // Accepted load, pause on door open, resume with START.
    key(11, 1);
    wait_run(lows);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check_lit("pause_cen", count_en, 0);
    check_lit("pause_busy", busy, 1);
    key(11, 0);
    cycle(0, 0, 1, 1);
    check_lit("paused_ignores_zero", busy, 1);
    key(11, 1);
    check_lit("resume_cen", count_en, 1);

    // Asynchronous reset in the middle of RUN.
    #2 clrn = 1'b0;
    #1;
    model_reset();
    check_lit("async_cen", count_en, 0);
    check_lit("async_busy", busy, 0);
    check_lit("async_digits", {mins, sec_tens, sec_ones}, 0);
    compare("async_reset");
    #3 clrn = 1'b1;

    // START in IDLE.
    key(11, 1);
`ifdef QUICK_START_EN
    check_lit("qs_digits", {mins, sec_tens, sec_ones}, 12'h030);
    check_lit("qs_loadn", loadn, 0);
    wait_run(lows);
    key(10, 1);
    key(9, 1); key(4, 1); key(5, 1); key(11, 1);
    wait_run(lows);
    cycle(0, 0, 1, 0);
    key(11, 1);
    check_lit("qs_add_sat", {mins, sec_tens, sec_ones}, 12'h959);
    check_lit("qs_add_loadn", loadn, 0);
    wait_run(lows);
    check_lit("qs_add_cen", count_en, 1);
    key(10, 1);
`else
    check_lit("idle_start_loadn", loadn, 1);
    check_lit("idle_start_busy", busy, 0);
`endif
    check_lit("model_add30_sat", add30(945), 959);
    check_lit("model_add30_carry", add30(145), 215);

    // Randomized traffic against the model.
    begin
      bit dc;
      dc = 1;
      for (int i = 0; i < 4000; i++) begin
        int r, kc;
        bit kv, tz;
        if ($urandom_range(0, 19) == 0) dc = !dc;
        kv = ($urandom_range(0, 99) < 35);
        r  = $urandom_range(0, 9);
        if (r < 5)       kc = $urandom_range(0, 9);
        else if (r < 8)  kc = 11;
        else if (r == 8) kc = 10;
        else             kc = $urandom_range(12, 15);
        tz = ($urandom_range(0, 9) == 0);
        cycle(kv, kc, dc, tz);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
